// File: rtl/acc_core_p_if.sv
// Load, start, read-back and architectural-state signals of acc_core_p.
// The bench or board wrapper owns master; the core owns slave.
interface acc_core_p_if #(
  parameter int W  = 8,
  parameter int AW = 4,
  parameter int PD = 16
);
  localparam int PW = $clog2(PD);

  logic            start;
  logic            prog_we;
  logic [PW-1:0]   prog_addr;
  logic [3+AW:0]   prog_data;
  logic            reg_we;
  logic [AW-1:0]   reg_addr;
  logic [W-1:0]    reg_wdata;
  logic [AW-1:0]   rd_addr;
  logic [W-1:0]    rd_data;
  logic            busy;
  logic            done;
  logic [W-1:0]    acc_o;
  logic [W-1:0]    ext_o;
  logic            cb_o;
  logic [PW-1:0]   pc_o;

  modport master (
    output start, prog_we, prog_addr, prog_data, reg_we, reg_addr, reg_wdata, rd_addr,
    input  rd_data, busy, done, acc_o, ext_o, cb_o, pc_o
  );

  modport slave (
    input  start, prog_we, prog_addr, prog_data, reg_we, reg_addr, reg_wdata, rd_addr,
    output rd_data, busy, done, acc_o, ext_o, cb_o, pc_o
  );
endinterface

// File: rtl/acc_core_p.sv
// Multi-cycle accumulator processor: single-cycle ALU ops from an internal
// program memory and register file, plus a W-iteration restoring divider.
module acc_core_p #(
  parameter int W  = 8,
  parameter int AW = 4,
  parameter int PD = 16
) (
  input logic         clk,
  input logic         rst_n,
  acc_core_p_if.slave bus
);
  localparam int PW = $clog2(PD);
  localparam int IW = 4 + AW;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DIV, HALT} state_t;

  state_t        state_reg, state_next;
  logic [W-1:0]  acc_reg, acc_next;
  logic [W-1:0]  ext_reg, ext_next;
  logic          cb_reg, cb_next;
  logic [PW-1:0] pc_reg, pc_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [W-1:0]  quo_reg, quo_next;
  logic [W-1:0]  rem_reg, rem_next;
  logic [W-1:0]  dvs_reg, dvs_next;

  logic [IW-1:0] prog_mem [PD];
  logic [W-1:0]  reg_mem [2**AW];

  logic [IW-1:0] instr;
  logic [3:0]    opcode;
  logic [AW-1:0] k;
  logic [W-1:0]  r;
  logic [PW-1:0] pc_inc;
  logic [PW-1:0] br_target;
  logic          idle_like;
  logic          sta_we;
  logic [W:0]    rem_sh;
  logic [W:0]    rem_sub;
  logic [W-1:0]  quo_step;
  logic [W-1:0]  rem_step;
  logic [2*W-1:0] prod;

  assign instr     = prog_mem[pc_reg];
  assign opcode    = instr[3+AW:AW];
  assign k         = instr[AW-1:0];
  assign r         = reg_mem[k];
  assign pc_inc    = (pc_reg == PW'(PD - 1)) ? '0 : pc_reg + PW'(1);
  assign br_target = PW'(int'(k) % PD);
  assign idle_like = (state_reg == IDLE) || (state_reg == HALT);
  assign sta_we    = (state_reg == RUN) && (opcode == 4'hA);
  assign prod      = {{W{1'b0}}, acc_reg} * {{W{1'b0}}, r};

  // One restoring step; a zero divisor naturally yields all-ones and the dividend.
  assign rem_sh   = {rem_reg, quo_reg[W-1]};
  assign rem_sub  = rem_sh - {1'b0, dvs_reg};
  assign quo_step = {quo_reg[W-2:0], ~rem_sub[W]};
  assign rem_step = rem_sub[W] ? rem_sh[W-1:0] : rem_sub[W-1:0];

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    ext_next   = ext_reg;
    cb_next    = cb_reg;
    pc_next    = pc_reg;
    cnt_next   = cnt_reg;
    quo_next   = quo_reg;
    rem_next   = rem_reg;
    dvs_next   = dvs_reg;
    case (state_reg)
      IDLE, HALT: begin
        if (bus.start) begin
          state_next = RUN;
          pc_next    = '0;
        end
      end
      RUN: begin
        pc_next = pc_inc;
        case (opcode)
          4'h0: begin
            if (int'(k) < 8) begin
              case (k[2:0])
                3'd1: acc_next = {acc_reg[W-2:0], 1'b0};
                3'd2: acc_next = {1'b0, acc_reg[W-1:1]};
                3'd3: acc_next = {acc_reg[0], acc_reg[W-1:1]};
                3'd4: acc_next = {acc_reg[W-2:0], acc_reg[W-1]};
                3'd5: acc_next = {acc_reg[W-1], acc_reg[W-1:1]};
                3'd6: {cb_next, acc_next} = {1'b0, acc_reg} + (W+1)'(1);
                3'd7: {cb_next, acc_next} = {1'b0, acc_reg} - (W+1)'(1);
                default: ;
              endcase
            end
          end
          4'h1: {cb_next, acc_next} = {1'b0, acc_reg} + {1'b0, r};
          4'h2: {cb_next, acc_next} = {1'b0, acc_reg} - {1'b0, r};
          4'h3: {ext_next, acc_next} = prod;
          4'h4: begin
            state_next = DIV;
            pc_next    = pc_reg;
            quo_next   = acc_reg;
            rem_next   = '0;
            dvs_next   = r;
            cnt_next   = CW'(W);
          end
          4'h5: acc_next = acc_reg & r;
          4'h6: acc_next = acc_reg ^ r;
          4'h7: cb_next  = (acc_reg < r);
          4'h8: pc_next  = cb_reg ? br_target : pc_inc;
          4'h9: acc_next = r;
          4'hB: pc_next  = br_target;
          4'hF: begin
            state_next = HALT;
            pc_next    = pc_reg;
          end
          default: ;
        endcase
      end
      DIV: begin
        quo_next = quo_step;
        rem_next = rem_step;
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          acc_next   = quo_step;
          ext_next   = rem_step;
          cb_next    = (dvs_reg == '0);
          pc_next    = pc_inc;
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      ext_reg   <= '0;
      cb_reg    <= 1'b0;
      pc_reg    <= '0;
      cnt_reg   <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      dvs_reg   <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      ext_reg   <= ext_next;
      cb_reg    <= cb_next;
      pc_reg    <= pc_next;
      cnt_reg   <= cnt_next;
      quo_reg   <= quo_next;
      rem_reg   <= rem_next;
      dvs_reg   <= dvs_next;
    end
  end

  // Memories keep their contents through reset so a program survives an abort.
  always_ff @(posedge clk) begin
    if (bus.prog_we && idle_like && (int'(bus.prog_addr) < PD))
      prog_mem[bus.prog_addr] <= bus.prog_data;
  end

  always_ff @(posedge clk) begin
    if (sta_we)
      reg_mem[k] <= acc_reg;
    else if (bus.reg_we && idle_like)
      reg_mem[bus.reg_addr] <= bus.reg_wdata;
  end

  assign bus.rd_data = reg_mem[bus.rd_addr];
  assign bus.busy    = (state_reg == RUN) || (state_reg == DIV);
  assign bus.done    = (state_reg == HALT);
  assign bus.acc_o   = acc_reg;
  assign bus.ext_o   = ext_reg;
  assign bus.cb_o    = cb_reg;
  assign bus.pc_o    = pc_reg;
endmodule

// File: tb/tb_acc_core_p.sv
// Directed programs against an instruction-level model of acc_core_p that is
// compared with the core every cycle, plus hand-computed literal checks.
module tb_acc_core_p;
  localparam int W  = 8;
  localparam int AW = 4;
  localparam int PD = 16;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DIV  = 2;
  localparam int M_HALT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  acc_core_p_if #(.W(W), .AW(AW), .PD(PD)) bus ();
  acc_core_p #(.W(W), .AW(AW), .PD(PD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  // instruction-level model state
  int         m_mode = M_IDLE;
  int         m_acc = 0, m_ext = 0, m_cb = 0, m_left = 0;
  int         m_qa = 0, m_qe = 0, m_qc = 0;
  logic [3:0] m_pc = 4'd0;
  logic [7:0] m_prog [16];
  logic [7:0] m_regs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [3:0] op;
    logic [3:0] mk;
    int r, t;
    if (!rst_n) begin
      m_mode = M_IDLE; m_acc = 0; m_ext = 0; m_cb = 0; m_pc = 4'd0; m_left = 0;
    end else if (m_mode == M_IDLE || m_mode == M_HALT) begin
      if (bus.prog_we) m_prog[bus.prog_addr] = bus.prog_data;
      if (bus.reg_we) m_regs[bus.reg_addr] = bus.reg_wdata;
      if (bus.start) begin m_mode = M_RUN; m_pc = 4'd0; end
    end else if (m_mode == M_DIV) begin
      m_left--;
      if (m_left == 0) begin
        m_acc = m_qa; m_ext = m_qe; m_cb = m_qc;
        m_pc = 4'((int'(m_pc) + 1) % PD);
        m_mode = M_RUN;
      end
    end else begin
      op = m_prog[m_pc][7:4];
      mk = m_prog[m_pc][3:0];
      r  = int'(m_regs[mk]);
      t  = (int'(m_pc) + 1) % PD;
      m_pc = 4'(t);
      case (op)
        4'h0: case (mk)
          4'd1: m_acc = (m_acc * 2) % 256;
          4'd2: m_acc = m_acc / 2;
          4'd3: m_acc = m_acc / 2 + (m_acc % 2) * 128;
          4'd4: m_acc = (m_acc * 2) % 256 + m_acc / 128;
          4'd5: m_acc = m_acc / 2 + (m_acc / 128) * 128;
          4'd6: begin m_cb = (m_acc == 255) ? 1 : 0; m_acc = (m_acc + 1) % 256; end
          4'd7: begin m_cb = (m_acc == 0) ? 1 : 0; m_acc = (m_acc + 255) % 256; end
          default: ;
        endcase
        4'h1: begin m_cb = (m_acc + r) / 256; m_acc = (m_acc + r) % 256; end
        4'h2: begin m_cb = (m_acc < r) ? 1 : 0; m_acc = (m_acc - r + 256) % 256; end
        4'h3: begin m_ext = (m_acc * r) / 256; m_acc = (m_acc * r) % 256; end
        4'h4: begin
          if (r == 0) begin m_qa = 255; m_qe = m_acc; m_qc = 1; end
          else begin m_qa = m_acc / r; m_qe = m_acc % r; m_qc = 0; end
          m_mode = M_DIV; m_left = W;
          m_pc = 4'((t + PD - 1) % PD);
        end
        4'h5: m_acc = m_acc & r;
        4'h6: m_acc = m_acc ^ r;
        4'h7: m_cb = (m_acc < r) ? 1 : 0;
        4'h8: if (m_cb == 1) m_pc = 4'(int'(mk) % PD);
        4'h9: m_acc = r;
        4'hA: m_regs[mk] = 8'(m_acc);
        4'hB: m_pc = 4'(int'(mk) % PD);
        4'hF: begin m_mode = M_HALT; m_pc = 4'((t + PD - 1) % PD); end
        default: ;
      endcase
    end
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk);
      model_step();
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      chk("busy", 32'(bus.busy), 32'(m_mode == M_RUN || m_mode == M_DIV));
      chk("done", 32'(bus.done), 32'(m_mode == M_HALT));
      chk("acc",  32'(bus.acc_o), m_acc);
      chk("ext",  32'(bus.ext_o), m_ext);
      chk("cb",   32'(bus.cb_o), m_cb);
      chk("pc",   32'(bus.pc_o), 32'(m_pc));
      if (!$isunknown(m_regs[bus.rd_addr]))
        chk("rd_data", 32'(bus.rd_data), 32'(m_regs[bus.rd_addr]));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_reg(input int a, input int d);
    bus.reg_we = 1'b1; bus.reg_addr = 4'(a); bus.reg_wdata = 8'(d);
    tick();
    bus.reg_we = 1'b0;
  endtask

  task automatic set_prog(input int a, input int d);
    bus.prog_we = 1'b1; bus.prog_addr = 4'(a); bus.prog_data = 8'(d);
    tick();
    bus.prog_we = 1'b0;
  endtask

  task automatic start_run();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Counts edges after the start-accepting edge until done rises.
  task automatic wait_done(input string name, output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_seen"}, 32'(bus.done), 1);
    #1;
    $display("run %s: cycles=%0d acc=%0h ext=%0h cb=%0d pc=%0d",
             name, n, bus.acc_o, bus.ext_o, bus.cb_o, bus.pc_o);
  endtask

  task automatic run4(input string name, input int i0, input int i1, input int i2,
                      input int i3, output int n);
    set_prog(0, i0); set_prog(1, i1); set_prog(2, i2); set_prog(3, i3);
    start_run();
    wait_done(name, n);
  endtask

  task automatic load_div_prog();
    set_prog(0, 'h91); set_prog(1, 'h42); set_prog(2, 'h85);
    set_prog(3, 'h07); set_prog(4, 'hF0); set_prog(5, 'hF0);
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.reg_we = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0; bus.rd_addr = '0;
    fork
      model_loop();
      compare_loop();
    join_none

    repeat (2) @(negedge clk);
    chk("rst_acc", 32'(bus.acc_o), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_pc", 32'(bus.pc_o), 0);
    #1 rst_n = 1'b1;
    tick();

    // 43 / 5 with ignored busy-time writes and start
    set_reg(1, 43); set_reg(2, 5);
    load_div_prog();
    start_run();
    repeat (2) tick();
    bus.reg_we = 1'b1; bus.reg_addr = 4'd1; bus.reg_wdata = 8'h77;
    bus.prog_we = 1'b1; bus.prog_addr = 4'd4; bus.prog_data = 8'h00;
    bus.start = 1'b1;
    tick();
    bus.reg_we = 1'b0; bus.prog_we = 1'b0; bus.start = 1'b0;
    repeat (7) tick();
    chk("div_acc", 32'(bus.acc_o), 8);
    chk("div_ext", 32'(bus.ext_o), 3);
    chk("div_cb", 32'(bus.cb_o), 0);
    wait_done("div43_5", n);
    chk("div_cycles", 10 + n, 13);
    chk("div_final_acc", 32'(bus.acc_o), 7);
    chk("div_final_cb", 32'(bus.cb_o), 0);
    bus.rd_addr = 4'd1;
    #1 chk("busy_write_ignored", 32'(bus.rd_data), 43);

    // ADD with carry; HLT loaded in the same cycle as start
    set_reg(0, 200); set_reg(1, 100);
    set_prog(0, 'h90); set_prog(1, 'h11);
    bus.prog_we = 1'b1; bus.prog_addr = 4'd2; bus.prog_data = 8'hF0; bus.start = 1'b1;
    tick();
    bus.prog_we = 1'b0; bus.start = 1'b0;
    wait_done("add", n);
    chk("add_cycles", n, 3);
    chk("add_acc", 32'(bus.acc_o), 44);
    chk("add_cb", 32'(bus.cb_o), 1);
    run4("sub", 'h21, 'hF0, 'hF0, 'hF0, n);
    chk("sub_acc", 32'(bus.acc_o), 200);
    chk("sub_cb", 32'(bus.cb_o), 1);

    set_reg(1, 3);
    run4("mul", 'h90, 'h31, 'hF0, 'hF0, n);
    chk("mul_acc", 32'(bus.acc_o), 'h58);
    chk("mul_ext", 32'(bus.ext_o), 'h02);
    chk("mul_cb", 32'(bus.cb_o), 1);

    set_reg(5, 'h80); set_reg(6, 'h8F); set_reg(7, 'hFF);
    run4("ror2", 'h95, 'h03, 'h03, 'hF0, n);
    chk("ror_acc", 32'(bus.acc_o), 'h20);
    run4("rol", 'h95, 'h04, 'hF0, 'hF0, n);
    chk("rol_acc", 32'(bus.acc_o), 'h01);
    run4("asr", 'h96, 'h05, 'hF0, 'hF0, n);
    chk("asr_acc", 32'(bus.acc_o), 'hC7);
    run4("inc", 'h97, 'h06, 'hF0, 'hF0, n);
    chk("inc_acc", 32'(bus.acc_o), 0);
    chk("inc_cb", 32'(bus.cb_o), 1);
    run4("shl_shr", 'h96, 'h01, 'h02, 'hF0, n);
    chk("shift_acc", 32'(bus.acc_o), 'h0F);
    chk("shift_cb", 32'(bus.cb_o), 1);
    run4("sta_xor", 'h96, 'hA8, 'h65, 'hF0, n);
    chk("xor_acc", 32'(bus.acc_o), 'h0F);
    bus.rd_addr = 4'd8;
    #1 chk("sta_rd", 32'(bus.rd_data), 'h8F);

    // divide by zero keeps the normal divide latency
    set_reg(0, 9); set_reg(1, 0);
    run4("div0", 'h90, 'h41, 'hF0, 'hF0, n);
    chk("div0_cycles", n, 11);
    chk("div0_acc", 32'(bus.acc_o), 'hFF);
    chk("div0_ext", 32'(bus.ext_o), 9);
    chk("div0_cb", 32'(bus.cb_o), 1);

    // CMP then BRC to 0 spins until reset
    set_reg(2, 10);
    set_prog(0, 'h90); set_prog(1, 'h72); set_prog(2, 'h80);
    start_run();
    repeat (20) tick();
    chk("loop_busy", 32'(bus.busy), 1);
    chk("loop_done", 32'(bus.done), 0);
    chk("loop_cb", 32'(bus.cb_o), 1);
    rst_n = 1'b0;
    #1 chk("loop_rst_busy", 32'(bus.busy), 0);
    chk("loop_rst_acc", 32'(bus.acc_o), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // reset three cycles into a divide
    set_reg(1, 43); set_reg(2, 5);
    load_div_prog();
    start_run();
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_acc", 32'(bus.acc_o), 0);
    chk("abort_ext", 32'(bus.ext_o), 0);
    chk("abort_cb", 32'(bus.cb_o), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_pc", 32'(bus.pc_o), 0);
    tick();
    rst_n = 1'b1;
    bus.rd_addr = 4'd1;
    #1 chk("abort_r1", 32'(bus.rd_data), 43);
    bus.rd_addr = 4'd2;
    #1 chk("abort_r2", 32'(bus.rd_data), 5);
    tick();
    start_run();
    wait_done("rerun", n);
    chk("rerun_cycles", n, 13);
    chk("rerun_acc", 32'(bus.acc_o), 7);
    chk("rerun_ext", 32'(bus.ext_o), 3);

    // sequential pc wraps from PD-1 back to 0
    set_reg(3, 0); set_reg(4, 'hFF);
    set_prog(0, 'h85); set_prog(1, 'h73); set_prog(2, 'hBE);
    set_prog(5, 'hF0); set_prog(14, 'h74); set_prog(15, 'h00);
    start_run();
    wait_done("wrap", n);
    chk("wrap_cycles", n, 7);
    chk("wrap_pc", 32'(bus.pc_o), 5);
    chk("wrap_cb", 32'(bus.cb_o), 1);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
